// File: rtl/cl2st_gearbox.sv
// rtl/cl2st_gearbox.sv - header-framed cache-line to byte-stream gearbox
// Buffers one complete frame packed by byte address, then streams it ST_BYTES per beat.
module cl2st_gearbox #(
  parameter int BUS_W    = 512,
  parameter int HEAD_W   = 8,
  parameter int ST_BYTES = 3,
  parameter int DEPTH    = 64,
  parameter int W_LEN    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BUS_W-1:0]              bus_data,
  input  logic                          bus_en,
  output logic                          bus_ready,
  input  logic                          st_ready,
  output logic [8*ST_BYTES-1:0]         st_data,
  output logic                          st_valid,
  output logic                          st_sop,
  output logic                          st_eop,
  output logic [$clog2(ST_BYTES+1)-1:0] st_nbytes,
  output logic [W_LEN-1:0]              st_len,
  output logic                          err_valid,
  output logic [1:0]                    err_code
);

  localparam int PB    = (BUS_W - HEAD_W) / 8;
  localparam int LW    = HEAD_W - 2;
  localparam int BUF_B = DEPTH * PB;
  localparam int AW    = $clog2(BUF_B);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NBW   = $clog2(ST_BYTES + 1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, SEND} state_t;

  state_t                state, next_state;
  logic                  live;
  logic [W_LEN-1:0]      wr_cnt, rd_ptr;
  logic [CW-1:0]         cl_cnt;
  logic [7:0]            mem [BUF_B];

  logic [1:0]            flag;
  logic [W_LEN-1:0]      cl_len, total, wr_base, rem, n_beats;
  logic                  accept, bad_len, full, last_beat;
  logic                  store, restart, err_now;
  logic [1:0]            code_now;
  logic [8*ST_BYTES-1:0] beat;
  logic [NBW-1:0]        beat_nb;

  assign flag    = bus_data[BUS_W-1 -: 2];
  assign cl_len  = W_LEN'(bus_data[BUS_W-3 -: LW]);
  assign accept  = bus_en & bus_ready;
  assign bad_len = cl_len > W_LEN'(PB);
  assign full    = cl_cnt == CW'(DEPTH);
  assign total   = wr_cnt + cl_len;
  assign wr_base = restart ? '0 : wr_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= next_state;
      live  <= 1'b1;
    end
  end

  // Next state plus the per-CL storage and error decisions
  always_comb begin
    next_state = state;
    store      = 1'b0;
    restart    = 1'b0;
    err_now    = 1'b0;
    code_now   = 2'd0;
    case (state)
      IDLE: if (accept) begin
        if (bad_len) begin
          err_now    = 1'b1;
          next_state = flag[0] ? IDLE : DISCARD;
        end else if (flag[1]) begin
          store      = 1'b1;
          restart    = 1'b1;
          next_state = flag[0] ? ((cl_len != '0) ? SEND : IDLE) : RECV;
        end else begin
          err_now  = 1'b1;
          code_now = 2'd1;
        end
      end
      RECV: if (accept) begin
        if (bad_len) begin
          err_now    = 1'b1;
          next_state = flag[0] ? IDLE : DISCARD;
        end else if (flag[1]) begin
          err_now    = 1'b1;
          code_now   = 2'd2;
          store      = 1'b1;
          restart    = 1'b1;
          next_state = flag[0] ? ((cl_len != '0) ? SEND : IDLE) : RECV;
        end else if (full) begin
          err_now    = 1'b1;
          code_now   = 2'd3;
          next_state = flag[0] ? IDLE : DISCARD;
        end else begin
          store      = 1'b1;
          next_state = flag[0] ? ((total != '0) ? SEND : IDLE) : RECV;
        end
      end
      DISCARD: if (accept) begin
        if (flag == 2'b10) begin
          if (bad_len) begin
            err_now = 1'b1;
          end else begin
            store      = 1'b1;
            restart    = 1'b1;
            next_state = RECV;
          end
        end else if (flag[0]) begin
          next_state = IDLE;
        end
      end
      SEND: if (st_valid && st_ready && st_eop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus_ready = live && (state != SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      cl_cnt    <= '0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= err_now;
      if (err_now) err_code <= code_now;
      if (next_state == IDLE || next_state == DISCARD) begin
        wr_cnt <= '0;
        cl_cnt <= '0;
      end else if (store) begin
        wr_cnt <= wr_base + cl_len;
        cl_cnt <= restart ? CW'(1) : cl_cnt + CW'(1);
      end
    end
  end

  // Payload bytes land at their final frame offset, so the read side never sees CL boundaries
  always_ff @(posedge clk) begin
    if (store) begin
      for (int i = 0; i < PB; i++) begin
        if (W_LEN'(i) < cl_len) mem[AW'(wr_base + W_LEN'(i))] <= bus_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    beat = '0;
    for (int j = 0; j < ST_BYTES; j++) begin
      if (rd_ptr + W_LEN'(j) < wr_cnt) beat[8*j +: 8] = mem[AW'(rd_ptr + W_LEN'(j))];
    end
  end

  assign rem       = wr_cnt - rd_ptr;
  assign beat_nb   = (rem >= W_LEN'(ST_BYTES)) ? NBW'(ST_BYTES) : NBW'(rem);
  assign last_beat = ({1'b0, rd_ptr} + (W_LEN+1)'(ST_BYTES)) >= {1'b0, wr_cnt};
  assign n_beats   = W_LEN'(({1'b0, wr_cnt} + (W_LEN+1)'(ST_BYTES-1)) / (W_LEN+1)'(ST_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      st_valid  <= 1'b0;
      st_data   <= '0;
      st_sop    <= 1'b0;
      st_eop    <= 1'b0;
      st_nbytes <= '0;
      st_len    <= '0;
    end else if (state != SEND) begin
      rd_ptr   <= '0;
      st_valid <= 1'b0;
      st_sop   <= 1'b0;
      st_eop   <= 1'b0;
    end else if (!st_valid || st_ready) begin
      if (rd_ptr < wr_cnt) begin
        st_valid  <= 1'b1;
        st_data   <= beat;
        st_nbytes <= beat_nb;
        st_sop    <= (rd_ptr == '0);
        st_eop    <= last_beat;
        st_len    <= n_beats;
        rd_ptr    <= rd_ptr + W_LEN'(ST_BYTES);
      end else begin
        st_valid <= 1'b0;
        st_sop   <= 1'b0;
        st_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cl2st_gearbox.sv
// tb/tb_cl2st_gearbox.sv - scoreboard bench for cl2st_gearbox
// Frame-level reference model feeds expected beats and errors; a monitor pops and compares.
module tb_cl2st_gearbox;

  localparam int ST    = 3;
  localparam int DEPTH = 4;
  localparam int PB    = 63;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  nb;
    logic        sop;
    logic        eop;
    logic [15:0] len;
  } beat_t;

  typedef struct {
    int code;
    int cyc;
  } err_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] bus_data;
  logic         bus_en;
  logic         bus_ready;
  logic         st_ready;
  logic [23:0]  st_data;
  logic         st_valid, st_sop, st_eop;
  logic [1:0]   st_nbytes;
  logic [15:0]  st_len;
  logic         err_valid;
  logic [1:0]   err_code;

  cl2st_gearbox #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
    .st_ready(st_ready), .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
    .st_eop(st_eop), .st_nbytes(st_nbytes), .st_len(st_len),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 0;
  int sop_cyc, eop_cyc;

  beat_t exp_q[$];
  err_t  err_q[$];

  int         m_state = 0;
  logic [7:0] m_frame[$];
  int         m_ncl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void m_err(int code, int c);
    err_t e;
    e.code = code;
    e.cyc  = c;
    err_q.push_back(e);
  endfunction

  function automatic void m_clear();
    m_frame.delete();
    m_ncl = 0;
  endfunction

  function automatic void m_load(bit fresh, int len, logic [503:0] pay);
    if (fresh) m_clear();
    for (int i = 0; i < len; i++) m_frame.push_back(pay[8*i +: 8]);
    m_ncl++;
  endfunction

  function automatic void m_emit();
    int n, nb;
    n  = m_frame.size();
    nb = (n + ST - 1) / ST;
    for (int b = 0; b < nb; b++) begin
      beat_t t;
      t.data = '0;
      for (int k = 0; k < ST; k++)
        if (b*ST + k < n) t.data[8*k +: 8] = m_frame[b*ST + k];
      t.nb  = 2'((n - b*ST >= ST) ? ST : n - b*ST);
      t.sop = (b == 0);
      t.eop = (b == nb - 1);
      t.len = 16'(nb);
      exp_q.push_back(t);
    end
    m_clear();
    m_state = 0;
  endfunction

  function automatic void model_accept(logic [1:0] flag, int len, logic [503:0] pay, int c);
    bit s, e;
    s = flag[1];
    e = flag[0];
    case (m_state)
      0: if (len > PB) begin
           m_err(0, c); m_state = e ? 0 : 2;
         end else if (s) begin
           m_load(1, len, pay);
           if (e) m_emit(); else m_state = 1;
         end else m_err(1, c);
      1: if (len > PB) begin
           m_err(0, c); m_clear(); m_state = e ? 0 : 2;
         end else if (s) begin
           m_err(2, c); m_load(1, len, pay);
           if (e) m_emit();
         end else if (m_ncl == DEPTH) begin
           m_err(3, c); m_clear(); m_state = e ? 0 : 2;
         end else begin
           m_load(0, len, pay);
           if (e) m_emit();
         end
      default: if (flag == 2'b10) begin
           if (len > PB) m_err(0, c);
           else begin m_load(1, len, pay); m_state = 1; end
         end else if (e) m_state = 0;
    endcase
  endfunction

  function automatic logic [503:0] rand_pay();
    logic [503:0] p;
    for (int i = 0; i < 63; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  task automatic send_cl(input logic [1:0] flag, input int len, input logic [503:0] pay);
    int waitc;
    waitc = 0;
    bus_data = {flag, 6'(len), pay};
    bus_en   = 1'b1;
    while (!bus_ready && waitc < 3000) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus_ready) begin
      check("bus_ready_timeout", 0, 1);
      bus_en = 1'b0;
    end else begin
      @(posedge clk); #1;
      model_accept(flag, len, pay, cyc);
      bus_en = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || st_valid) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", k < 3000, 1);
  endtask

  // Sink readiness
  initial begin
    st_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       st_ready = 1'b1;
        1:       st_ready = 1'($urandom_range(0, 1));
        default: st_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  beat_t cur, snap, e;
  err_t  ee;
  bit    prev_stall = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        cur = {st_data, st_nbytes, st_sop, st_eop, st_len};
        if (prev_stall) begin
          check("stall_valid", st_valid, 1);
          check("stall_hold", cur, snap);
        end
        if (st_valid && st_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("beat_data", st_data, e.data);
            check("beat_nbytes", st_nbytes, e.nb);
            check("beat_sop", st_sop, e.sop);
            check("beat_eop", st_eop, e.eop);
            check("beat_len", st_len, e.len);
            if (e.sop) sop_cyc = cyc;
            if (e.eop) eop_cyc = cyc;
          end
        end
        prev_stall = st_valid && !st_ready;
        snap = cur;
        if (err_valid) begin
          if (err_q.size() == 0) check("unexpected_err", err_code, 4);
          else begin
            ee = err_q.pop_front();
            check("err_code", err_code, ee.code);
            check("err_cycle", cyc, ee.cyc);
          end
        end
      end
    end
  end

  logic [503:0] pa, pb, pc;
  int k;
  initial begin
    bus_en   = 1'b0;
    bus_data = '0;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("reset_outputs", {bus_ready, st_data, st_valid, st_sop, st_eop, st_nbytes, st_len, err_valid, err_code}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_before_edge", bus_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", bus_ready, 1);

    // Single CL, 7 bytes
    send_cl(2'b11, 7, rand_pay());
    drain();

    // Three-CL frame, sink always ready
    pa = rand_pay(); pb = rand_pay(); pc = rand_pay();
    send_cl(2'b10, 63, pa);
    send_cl(2'b00, 5, pb);
    send_cl(2'b01, 63, pc);
    check("ready_drop_after_end", bus_ready, 0);
    k = 0;
    while (!st_valid && k < 5) begin @(posedge clk); #1; k++; end
    check("sop_latency_le3", k <= 3, 1);
    drain();
    check("no_bubbles", eop_cyc - sop_cyc, 43);
    check("ready_back_after_eop", bus_ready, 1);

    // Same frame with a stalling sink
    rdy_mode = 1;
    send_cl(2'b10, 63, pa);
    send_cl(2'b00, 5, pb);
    send_cl(2'b01, 63, pc);
    drain();

    // Orphan body then a short complete frame
    send_cl(2'b00, 5, rand_pay());
    drain();
    send_cl(2'b11, 3, rand_pay());
    drain();

    // Restart inside a frame
    send_cl(2'b10, 10, rand_pay());
    send_cl(2'b10, 4, rand_pay());
    send_cl(2'b01, 8, rand_pay());
    drain();

    // Overflow with DEPTH=4
    send_cl(2'b10, 20, rand_pay());
    for (int i = 0; i < 5; i++) begin
      send_cl(2'b00, 20, rand_pay());
      check("ready_during_overflow", bus_ready, 1);
    end
    send_cl(2'b01, 20, rand_pay());
    drain();
    check("ready_after_overflow", bus_ready, 1);

    // Random CL mix
    for (int i = 0; i < 80; i++) begin
      logic [1:0] f;
      f = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      send_cl(f, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 63), rand_pay());
    end
    send_cl(2'b01, 9, rand_pay());
    drain();

    // Reset while sending
    rdy_mode = 2;
    send_cl(2'b11, 63, rand_pay());
    repeat (3) begin @(posedge clk); #1; end
    check("valid_before_reset", st_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midsend_reset_outputs", {bus_ready, st_data, st_valid, st_sop, st_eop, st_nbytes, st_len, err_valid, err_code}, 0);
    exp_q.delete();
    err_q.delete();
    m_clear();
    m_state = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 0;
    check("ready_after_reset", bus_ready, 1);
    send_cl(2'b11, 4, rand_pay());
    drain();

    check("exp_queue_empty", exp_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cl2st_gearbox.md
# cl2st_gearbox

Parametrised successor to the single-frame CL-to-stream converter. It accepts cache-line (CL) buses carrying header-framed AFU frames, where each CL is a flag plus byte-length header over a byte payload. It buffers one complete frame, then emits it as an ST_BYTES-wide byte stream under per-beat valid/ready backpressure, with frame length, byte-accurate last beat and protocol-error reporting. It sits between the CL memory interface and the turbo decoder input.

## Interface
- BUS_W, 512: CL width; header is bits [BUS_W-1 -: HEAD_W], payload is the rest.
- HEAD_W, 8: header width.
  - Header top 2 bits are the flag: 10 start, 00 body, 01 end, 11 start+end.
  - Remaining bits are the valid payload byte count.
- ST_BYTES, 3: output beat width in bytes, 1..PB, where PB = (BUS_W-HEAD_W)/8 (63 by default).
- DEPTH, 64: buffer capacity in CLs (power of 2).
- W_LEN, 16: width of byte and beat counters.
- clk in 1: single clock; all logic rising-edge.
- rst_n in 1: asynchronous assert, active-low reset.
- bus_data in BUS_W: CL.
- bus_en in 1: CL valid. Accepted only when bus_en & bus_ready.
- bus_ready out 1: block can take a CL.
- st_ready in 1: sink accepts beat.
- st_data out 8*ST_BYTES: beat. Byte 0 is in the lowest bits and is the earliest frame byte.
- st_valid out 1: beat valid.
- st_sop out 1: first beat of frame.
- st_eop out 1: last beat of frame.
- st_nbytes out $clog2(ST_BYTES+1): valid bytes in beat.
- st_len out W_LEN: number of beats in the frame, ceil(bytes/ST_BYTES). Valid from sop through eop.
- err_valid out 1: one-cycle error pulse.
- err_code out 2: error cause.
  - 1: orphan body/end CL
  - 2: restart inside a frame
  - 3: buffer overflow
  - 0: illegal length

## Operation
- States:
  - IDLE: bus_ready=1.
  - RECV: bus_ready=1.
  - DISCARD: bus_ready=1, CLs are dropped.
  - SEND: bus_ready=0.
- IDLE transitions on an accepted CL:
  - flag 10 → RECV.
  - flag 11 → SEND.
  - flag 00 or 01: discard the CL, err 1, stay in IDLE.
- RECV transitions on an accepted CL:
  - 00 → stay in RECV.
  - 01 → SEND.
  - 10: flush the frame, err 2, the CL starts a new frame, stay in RECV.
  - 11: flush, err 2, the CL forms a complete frame → SEND.
- Each accepted CL in RECV writes its payload to the buffer and adds its length to the byte count. The count is W_LEN bits and wraps silently. Frames must stay below 2^W_LEN bytes.
- A length field greater than PB: err 0, frame flushed. Next state is DISCARD if the CL is not an end CL, otherwise IDLE.
- A CL arriving when DEPTH CLs are already stored: err 3, flush, then DISCARD. If that CL carries an end flag, go straight to IDLE.
- DISCARD: drop CLs until one with an end flag (01 or 11) is accepted, then return to IDLE. A start flag 10 in DISCARD begins a new frame in RECV.
- Payload bytes are packed contiguously across CLs:
  - Only the low `length` bytes of each CL are used.
  - CLs with length 0 are legal and contribute no bytes.
- A frame with a total of 0 bytes produces no output and returns to IDLE with no error.
- SEND:
  - Emit st_len beats. Every beat except the last has st_nbytes=ST_BYTES.
  - Last beat has st_nbytes = bytes - (st_len-1)*ST_BYTES; its unused bytes are zero.
  - When a single-beat frame is sent, st_sop and st_eop are both 1.
  - After the eop beat is accepted: flush the buffer, clear the counters, go to IDLE.
- Error pulses never coincide with st_valid activity for the same frame.

## Timing
- Reset values (async): all outputs 0. bus_ready rises on the first clk edge after rst_n deasserts.
- An active rst_n mid-frame aborts immediately. No eop and no error are reported.
- First beat:
  - st_valid with st_sop rises at most 3 cycles after the end CL is accepted.
  - bus_ready drops the cycle after the end CL is accepted.
- Throughput: one beat per cycle while st_ready=1, including across CL boundaries (prefetch the next CL). No bubbles inside a frame.
- Backpressure: while st_valid=1 and st_ready=0, st_data, st_sop, st_eop, st_nbytes and st_len hold stable. st_valid never drops without acceptance.
- bus_ready returns to 1 the cycle after the eop beat is accepted.
- err_valid is asserted the cycle after the offending CL is accepted.

## Test plan
- Single CL: flag 11, length 7, ST_BYTES=3.
  - Expect 3 beats with st_len=3 and nbytes 3, 3, 1.
  - Last beat data = {16'h0, byte6}. sop on beat 0, eop on beat 2.
- Three-CL frame with lengths 63, 5, 63, and st_ready held high.
  - Expect 131 bytes in order, 44 back-to-back beats, last nbytes=2, no bubble cycles.
- Same frame with st_ready toggling 1,0,0,1 pseudo-randomly.
  - Outputs stable while stalled; byte sequence identical to the previous test.
- Body CL (flag 00) in IDLE: err_code=1 pulse, no output. A following flag-11 length-3 frame yields 1 beat.
- Flag 10, then flag 10 again, then flag 01.
  - err_code=2 after the second CL.
  - Output contains only bytes of the second and third CLs.
- DEPTH=4 with 6 body CLs then an end CL: err_code=3 on the 5th CL, rest dropped, no output, bus_ready stays 1. Also assert rst_n low mid-SEND: all outputs 0 immediately.
